// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 decode/execute slice.
//   instr_structure : decoded control word carried from ID to EX to MEM
//   OP_* / FN_*     : primary opcode and R-type funct encodings
//   FD_*            : bit positions inside instr_structure.f_dec
//   BUBBLE          : all-zero control word used for squashed/unsupported slots
package mips_pkg;

  typedef struct packed {
    logic [4:0]  reg1;    // rs
    logic [4:0]  reg2;    // rt
    logic [4:0]  dest;    // rd (R-type) or rt (I-type)
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [5:0]  opcode;
    logic [31:0] imm;     // already extended
    logic [5:0]  f_dec;   // {regWrite,memToReg,memRead,memWrite,branch,jump}
  } instr_structure;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam int unsigned FD_REGWRITE = 5;
  localparam int unsigned FD_MEMTOREG = 4;
  localparam int unsigned FD_MEMREAD  = 3;
  localparam int unsigned FD_MEMWRITE = 2;
  localparam int unsigned FD_BRANCH   = 1;
  localparam int unsigned FD_JUMP     = 0;

  localparam instr_structure BUBBLE = '0;

  function automatic logic rtype_supported(input logic [5:0] fn);
    case (fn)
      FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU for the EX stage.
//   op1, op2 : rs / rt operand values
//   imm      : extended immediate from the decoded control word
//   shamt    : shift amount for sll/srl/sra
//   op_sel   : opcode_funct ({1,funct} for R-type, {0,opcode} otherwise)
//   result   : ALU result or memory address
//   equal    : op1 == op2, used for beq/bne resolution
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [31:0] imm,
  input  logic [4:0]  shamt,
  input  logic [6:0]  op_sel,
  output logic [31:0] result,
  output logic        equal
);

  always_comb begin
    result = '0;
    case (op_sel)
      {1'b1, FN_ADD}, {1'b1, FN_ADDU}: result = op1 + op2;
      {1'b1, FN_SUB}, {1'b1, FN_SUBU}: result = op1 - op2;
      {1'b1, FN_AND}:  result = op1 & op2;
      {1'b1, FN_OR}:   result = op1 | op2;
      {1'b1, FN_XOR}:  result = op1 ^ op2;
      {1'b1, FN_NOR}:  result = ~(op1 | op2);
      {1'b1, FN_SLT}:  result = {31'b0, ($signed(op1) < $signed(op2))};
      {1'b1, FN_SLTU}: result = {31'b0, (op1 < op2)};
      {1'b1, FN_SLL}:  result = op2 << shamt;
      {1'b1, FN_SRL}:  result = op2 >> shamt;
      {1'b1, FN_SRA}:  result = $unsigned($signed(op2) >>> shamt);
      {1'b0, OP_ADDI}, {1'b0, OP_ADDIU},
      {1'b0, OP_LW},   {1'b0, OP_SW}:    result = op1 + imm;
      {1'b0, OP_SLTI}:  result = {31'b0, ($signed(op1) < $signed(imm))};
      {1'b0, OP_SLTIU}: result = {31'b0, (op1 < imm)};
      {1'b0, OP_ANDI}:  result = op1 & imm;
      {1'b0, OP_ORI}:   result = op1 | imm;
      {1'b0, OP_XORI}:  result = op1 ^ imm;
      {1'b0, OP_LUI}:   result = imm;
      // Branch result is unused downstream but kept deterministic.
      {1'b0, OP_BEQ}, {1'b0, OP_BNE}: result = op1 - op2;
      default: result = '0;
    endcase
  end

  assign equal = (op1 == op2);

endmodule

// File: rtl/mips_decode_execute.sv
// Decode (ID) and execute (EX) stages of the 5-stage MIPS32 core.
//   clk, rst                 : clock, synchronous active-high reset
//   instr, PC_in, done_in    : fetch-stage instruction, its PC+4, valid token
//   op1_in, op2_in           : register-file read data for rfReadAddr_p0/p1
//   rfReadAddr_p0/p1         : rs / rt of instr (combinational)
//   iCont_toALU .. done_id   : ID-stage registers
//   result .. done_ex        : EX-stage registers, sent to MEM
// Build option MIPS_DX_FLUSH_EN: when defined, a taken branch squashes the
// ID and EX registers and a jump squashes the ID register; when undefined,
// instructions after a redirect execute (delay-slot behaviour).
// Unsupported encodings carry a BUBBLE control word and opcode_funct=0 but
// still latch operands, PC and done token.
module mips_decode_execute
  import mips_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    instr,
  input  logic [31:0]    PC_in,
  input  logic [31:0]    op1_in,
  input  logic [31:0]    op2_in,
  input  logic           done_in,
  output logic [4:0]     rfReadAddr_p0,
  output logic [4:0]     rfReadAddr_p1,
  output instr_structure iCont_toALU,
  output logic [6:0]     opcode_funct,
  output logic [31:0]    op1,
  output logic [31:0]    op2,
  output logic           jFlag,
  output logic [31:0]    PC_id,
  output logic           done_id,
  output logic [31:0]    result,
  output logic           zeroFlag,
  output logic [31:0]    hold_op2,
  output instr_structure iCont_out,
  output logic [31:0]    PC_ex,
  output logic           done_ex
);

  assign rfReadAddr_p0 = instr[25:21];
  assign rfReadAddr_p1 = instr[20:16];

  // ---------------- decode ----------------
  instr_structure dec;
  logic [6:0]     dec_opf;
  logic           dec_jump;
  logic [31:0]    jump_target;
  logic [5:0]     opc;
  logic [5:0]     fn;
  logic [31:0]    imm_sext;
  logic [31:0]    imm_ext;
  logic [4:0]     dest_sel;
  logic [5:0]     fd;
  logic           supported;

  always_comb begin
    opc       = instr[31:26];
    fn        = instr[5:0];
    imm_sext  = {{16{instr[15]}}, instr[15:0]};
    imm_ext   = imm_sext;
    dest_sel  = instr[20:16];
    fd        = '0;
    supported = 1'b0;
    case (opc)
      OP_RTYPE: begin
        supported       = rtype_supported(fn);
        fd[FD_REGWRITE] = 1'b1;
        dest_sel        = instr[15:11];
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        supported       = 1'b1;
        fd[FD_REGWRITE] = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        supported       = 1'b1;
        fd[FD_REGWRITE] = 1'b1;
        imm_ext         = {16'b0, instr[15:0]};
      end
      OP_LUI: begin
        supported       = 1'b1;
        fd[FD_REGWRITE] = 1'b1;
        imm_ext         = {instr[15:0], 16'b0};
      end
      OP_LW: begin
        supported       = 1'b1;
        fd[FD_REGWRITE] = 1'b1;
        fd[FD_MEMTOREG] = 1'b1;
        fd[FD_MEMREAD]  = 1'b1;
      end
      OP_SW: begin
        supported       = 1'b1;
        fd[FD_MEMWRITE] = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        supported     = 1'b1;
        fd[FD_BRANCH] = 1'b1;
      end
      OP_J: begin
        supported   = 1'b1;
        fd[FD_JUMP] = 1'b1;
        dest_sel    = '0;
      end
      default: supported = 1'b0;
    endcase

    dec     = BUBBLE;
    dec_opf = '0;
    if (supported) begin
      dec.reg1   = instr[25:21];
      dec.reg2   = instr[20:16];
      dec.dest   = dest_sel;
      dec.shamt  = instr[10:6];
      dec.funct  = fn;
      dec.opcode = opc;
      dec.imm    = imm_ext;
      dec.f_dec  = fd;
      dec_opf    = (opc == OP_RTYPE) ? {1'b1, fn} : {1'b0, opc};
    end
  end

  assign dec_jump    = dec.f_dec[FD_JUMP];
  assign jump_target = {PC_in[31:28], instr[25:0], 2'b00};

  // ---------------- execute ----------------
  logic [31:0] alu_result;
  logic        alu_eq;
  logic        br_taken;
  logic [31:0] br_target;

  mips_alu u_alu (
    .op1    (op1),
    .op2    (op2),
    .imm    (iCont_toALU.imm),
    .shamt  (iCont_toALU.shamt),
    .op_sel (opcode_funct),
    .result (alu_result),
    .equal  (alu_eq)
  );

  assign br_taken  = iCont_toALU.f_dec[FD_BRANCH] &
                     ((opcode_funct == {1'b0, OP_BEQ}) ? alu_eq : ~alu_eq);
  assign br_target = PC_id + {iCont_toALU.imm[29:0], 2'b00};

  // ---------------- flush control ----------------
  logic squash_id;
  logic squash_ex;

`ifdef MIPS_DX_FLUSH_EN
  // A taken branch in EX kills both younger slots; a jump in ID kills one.
  assign squash_id = zeroFlag | jFlag;
  assign squash_ex = zeroFlag;
`else
  assign squash_id = 1'b0;
  assign squash_ex = 1'b0;
`endif

  // ---------------- ID register ----------------
  always_ff @(posedge clk) begin
    if (rst || squash_id) begin
      iCont_toALU  <= BUBBLE;
      opcode_funct <= '0;
      op1          <= '0;
      op2          <= '0;
      jFlag        <= 1'b0;
      PC_id        <= '0;
      done_id      <= 1'b0;
    end else begin
      iCont_toALU  <= dec;
      opcode_funct <= dec_opf;
      op1          <= op1_in;
      op2          <= op2_in;
      jFlag        <= dec_jump;
      PC_id        <= dec_jump ? jump_target : PC_in;
      done_id      <= done_in;
    end
  end

  // ---------------- EX register ----------------
  always_ff @(posedge clk) begin
    if (rst || squash_ex) begin
      result    <= '0;
      zeroFlag  <= 1'b0;
      hold_op2  <= '0;
      iCont_out <= BUBBLE;
      PC_ex     <= '0;
      done_ex   <= 1'b0;
    end else begin
      result    <= alu_result;
      zeroFlag  <= br_taken;
      hold_op2  <= op2;
      iCont_out <= iCont_toALU;
      PC_ex     <= br_taken ? br_target : PC_id;
      done_ex   <= done_id;
    end
  end

endmodule

// File: tb/tb_mips_decode_execute.sv
// Self-checking bench for mips_decode_execute: directed test-plan steps
// followed by random instruction streams, compared against an ISA-level
// reference model of the two pipeline registers.
module tb_mips_decode_execute;
  import mips_pkg::*;

`ifdef MIPS_DX_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic [31:0]    instr;
  logic [31:0]    PC_in;
  logic [31:0]    op1_in;
  logic [31:0]    op2_in;
  logic           done_in;
  logic [4:0]     rfReadAddr_p0;
  logic [4:0]     rfReadAddr_p1;
  instr_structure iCont_toALU;
  logic [6:0]     opcode_funct;
  logic [31:0]    op1;
  logic [31:0]    op2;
  logic           jFlag;
  logic [31:0]    PC_id;
  logic           done_id;
  logic [31:0]    result;
  logic           zeroFlag;
  logic [31:0]    hold_op2;
  instr_structure iCont_out;
  logic [31:0]    PC_ex;
  logic           done_ex;

  mips_decode_execute dut (
    .clk           (clk),
    .rst           (rst),
    .instr         (instr),
    .PC_in         (PC_in),
    .op1_in        (op1_in),
    .op2_in        (op2_in),
    .done_in       (done_in),
    .rfReadAddr_p0 (rfReadAddr_p0),
    .rfReadAddr_p1 (rfReadAddr_p1),
    .iCont_toALU   (iCont_toALU),
    .opcode_funct  (opcode_funct),
    .op1           (op1),
    .op2           (op2),
    .jFlag         (jFlag),
    .PC_id         (PC_id),
    .done_id       (done_id),
    .result        (result),
    .zeroFlag      (zeroFlag),
    .hold_op2      (hold_op2),
    .iCont_out     (iCont_out),
    .PC_ex         (PC_ex),
    .done_ex       (done_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model slots.
  typedef struct packed {
    logic [31:0]    raw;
    logic           valid;
    instr_structure ic;
    logic [6:0]     opf;
    logic [31:0]    op1;
    logic [31:0]    op2;
    logic           jf;
    logic [31:0]    pc;
    logic           done;
  } id_t;

  typedef struct packed {
    logic [31:0]    result;
    logic           zf;
    logic [31:0]    hold;
    instr_structure ic;
    logic [31:0]    pc;
    logic           done;
  } ex_t;

  id_t m_id = '0;
  ex_t m_ex = '0;

  localparam logic [5:0] RFN [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                      6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
  localparam logic [5:0] IOP [12] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                                      6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic id_t ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic d);
    id_t r;
    logic [5:0] op, fn;
    logic ok, rw, mtr, mr, mw, br, jp;
    logic [4:0] dst;
    logic [31:0] imm;
    r = '0;
    op = i[31:26]; fn = i[5:0];
    ok = 0; rw = 0; mtr = 0; mr = 0; mw = 0; br = 0; jp = 0;
    dst = i[20:16];
    imm = {{16{i[15]}}, i[15:0]};
    if (op == 6'h00) begin
      ok  = fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                       6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
      rw  = 1;
      dst = i[15:11];
    end else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B}) begin
      ok = 1; rw = 1;
    end else if (op inside {6'h0C, 6'h0D, 6'h0E}) begin
      ok = 1; rw = 1; imm = {16'h0, i[15:0]};
    end else if (op == 6'h0F) begin
      ok = 1; rw = 1; imm = {i[15:0], 16'h0};
    end else if (op == 6'h23) begin
      ok = 1; rw = 1; mtr = 1; mr = 1;
    end else if (op == 6'h2B) begin
      ok = 1; mw = 1;
    end else if (op == 6'h04 || op == 6'h05) begin
      ok = 1; br = 1;
    end else if (op == 6'h02) begin
      ok = 1; jp = 1; dst = 0;
    end
    r.raw = i; r.valid = ok; r.op1 = a; r.op2 = b; r.done = d; r.pc = pc;
    if (ok) begin
      r.ic.reg1 = i[25:21]; r.ic.reg2 = i[20:16]; r.ic.dest = dst;
      r.ic.shamt = i[10:6]; r.ic.funct = fn; r.ic.opcode = op; r.ic.imm = imm;
      r.ic.f_dec = {rw, mtr, mr, mw, br, jp};
      r.opf = (op == 6'h00) ? {1'b1, fn} : {1'b0, op};
      r.jf  = jp;
      if (jp) r.pc = {pc[31:28], i[25:0], 2'b00};
    end
    return r;
  endfunction

  function automatic ex_t ref_exec(input id_t d);
    ex_t e;
    logic [5:0] op, fn;
    logic [4:0] sh;
    logic [31:0] a, b, se, ze, res;
    logic signed [31:0] sa, sb, si;
    logic taken;
    e = '0;
    op = d.raw[31:26]; fn = d.raw[5:0]; sh = d.raw[10:6];
    a = d.op1; b = d.op2; sa = d.op1; sb = d.op2;
    se = {{16{d.raw[15]}}, d.raw[15:0]}; ze = {16'h0, d.raw[15:0]}; si = se;
    res = 0; taken = 0;
    if (d.valid) begin
      if (op == 6'h00) begin
        case (fn)
          6'h20, 6'h21: res = a + b;
          6'h22, 6'h23: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h26: res = a ^ b;
          6'h27: res = ~(a | b);
          6'h2A: res = (sa < sb) ? 1 : 0;
          6'h2B: res = (a < b) ? 1 : 0;
          6'h00: res = b << sh;
          6'h02: res = b >> sh;
          6'h03: res = sb >>> sh;
          default: res = 0;
        endcase
      end else begin
        case (op)
          6'h08, 6'h09, 6'h23, 6'h2B: res = a + se;
          6'h0A: res = (sa < si) ? 1 : 0;
          6'h0B: res = (a < se) ? 1 : 0;
          6'h0C: res = a & ze;
          6'h0D: res = a | ze;
          6'h0E: res = a ^ ze;
          6'h0F: res = {d.raw[15:0], 16'h0};
          6'h04: begin res = a - b; taken = (a == b); end
          6'h05: begin res = a - b; taken = (a != b); end
          default: res = 0;
        endcase
      end
    end
    e.result = res; e.zf = taken; e.hold = d.op2; e.ic = d.ic; e.done = d.done;
    e.pc = taken ? d.pc + (se << 2) : d.pc;
    return e;
  endfunction

  task automatic compare_all();
    chk("iCont_toALU", 96'(iCont_toALU), 96'(m_id.ic));
    chk("opcode_funct", 96'(opcode_funct), 96'(m_id.opf));
    chk("op1", 96'(op1), 96'(m_id.op1));
    chk("op2", 96'(op2), 96'(m_id.op2));
    chk("jFlag", 96'(jFlag), 96'(m_id.jf));
    chk("PC_id", 96'(PC_id), 96'(m_id.pc));
    chk("done_id", 96'(done_id), 96'(m_id.done));
    chk("result", 96'(result), 96'(m_ex.result));
    chk("zeroFlag", 96'(zeroFlag), 96'(m_ex.zf));
    chk("hold_op2", 96'(hold_op2), 96'(m_ex.hold));
    chk("iCont_out", 96'(iCont_out), 96'(m_ex.ic));
    chk("PC_ex", 96'(PC_ex), 96'(m_ex.pc));
    chk("done_ex", 96'(done_ex), 96'(m_ex.done));
  endtask

  // One clock: drive inputs, check the combinational read addresses, advance
  // the model across the edge, then compare registered outputs at negedge.
  task automatic step(input logic r, input logic [31:0] i, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b, input logic d);
    id_t nid;
    ex_t nex;
    rst = r; instr = i; PC_in = pc; op1_in = a; op2_in = b; done_in = d;
    #1;
    chk("rfReadAddr_p0", 96'(rfReadAddr_p0), 96'(i[25:21]));
    chk("rfReadAddr_p1", 96'(rfReadAddr_p1), 96'(i[20:16]));
    nid = ref_decode(i, pc, a, b, d);
    nex = ref_exec(m_id);
    if (FLUSH && (m_ex.zf || m_id.jf)) nid = '0;
    if (FLUSH && m_ex.zf) nex = '0;
    if (r) begin nid = '0; nex = '0; end
    @(posedge clk);
    m_id = nid;
    m_ex = nex;
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [31:0] rand_instr();
    int unsigned k;
    logic [4:0] rs, rt, rd, sh;
    k = $urandom_range(0, 27);
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
    if (k < 13) return {6'h00, rs, rt, rd, sh, RFN[k]};
    if (k < 25) return {IOP[k-13], rs, rt, 16'($urandom)};
    if (k == 25) return {6'h02, 26'($urandom)};
    return $urandom;
  endfunction

  localparam logic [31:0] FILL = 32'hFC000000;  // unsupported encoding

  initial begin
    // Reset
    step(1, 32'h01095020, 32'h4, 32'h11, 32'h22, 1);
    step(1, 32'h01095020, 32'h4, 32'h11, 32'h22, 1);
    chk("rst_done_id", 96'(done_id), 96'(0));
    chk("rst_done_ex", 96'(done_ex), 96'(0));
    chk("rst_iCont_out", 96'(iCont_out), 96'(0));

    // add r10, r8, r9
    step(0, 32'h01095020, 32'h4, 5, 7, 1);
    step(0, FILL, 32'h8, 0, 0, 1);
    chk("add_result", 96'(result), 96'(12));
    chk("add_dest", 96'(iCont_out.dest), 96'(10));
    chk("add_regWrite", 96'(iCont_out.f_dec[5]), 96'(1));

    // lw r9, 8(r8)
    step(0, 32'h8D090008, 32'hC, 32'h100, 0, 1);
    step(0, FILL, 32'h10, 0, 0, 1);
    chk("lw_result", 96'(result), 96'(32'h108));
    chk("lw_memRead", 96'(iCont_out.f_dec[3]), 96'(1));
    chk("lw_memToReg", 96'(iCont_out.f_dec[4]), 96'(1));
    chk("lw_dest", 96'(iCont_out.dest), 96'(9));

    // beq r1, r2, +3 taken
    step(0, 32'h10220003, 32'h104, 5, 5, 1);
    step(0, 32'h20010001, 32'h108, 0, 0, 1);   // addi r1, r0, 1
    chk("beq_zeroFlag", 96'(zeroFlag), 96'(1));
    chk("beq_PC_ex", 96'(PC_ex), 96'(32'h110));
    step(0, 32'h20020002, 32'h10C, 0, 0, 1);   // addi r2, r0, 2
    chk("beq_zf_once", 96'(zeroFlag), 96'(0));
    chk("beq_slot1", 96'(iCont_out.dest), 96'(FLUSH ? 0 : 1));
    step(0, FILL, 32'h110, 0, 0, 1);
    chk("beq_slot2", 96'(iCont_out.dest), 96'(FLUSH ? 0 : 2));

    // j 0x00400010
    step(0, 32'h08100004, 32'h8, 0, 0, 1);
    chk("j_jFlag", 96'(jFlag), 96'(1));
    chk("j_PC_id", 96'(PC_id), 96'(32'h00400010));
    step(0, 32'h01095020, 32'hC, 1, 2, 1);
    chk("j_jf_once", 96'(jFlag), 96'(0));
    chk("j_slot", 96'(iCont_toALU.dest), 96'(FLUSH ? 0 : 10));

    // Random streams
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      step(($urandom_range(0, 60) == 0), rand_instr(), $urandom, a, b,
           1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
